// File: rtl/ram_sweep.sv
// ram_sweep: parametrised word-addressed register RAM with a hardware clear engine.
// Combinational read, synchronous write. A clear request starts a sweep that
// writes the fill value to every word, one word per cycle, over DEPTH cycles.
// Optional feature macro: RAM_SWEEP_FILL_EN. When it is defined, the fill_i
// port is added and its value is captured when the sweep starts. Otherwise the
// sweep writes zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal RAM operation; clear_i starts a sweep
// SWEEP | mem[ptr] <= fill each cycle; writes are dropped (drop_o)
module ram_sweep #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  in_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              clear_i,
`ifdef RAM_SWEEP_FILL_EN
  input  logic [WIDTH-1:0]  fill_i,
`endif
  output logic [WIDTH-1:0]  out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              drop_o
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, drop_q;
  logic              addr_ok, last_word, start;
  logic [WIDTH-1:0]  fill_val;

  // Out-of-range addresses exist when DEPTH is not a power of two.
  assign addr_ok   = ({1'b0, address_i} < DEPTH_EXT);
  assign last_word = (state_q == SWEEP) && (ptr_q == LAST_PTR);
  // A clear on the final sweep edge chains straight into a new sweep.
  assign start     = clear_i && ((state_q == IDLE) || last_word);

`ifdef RAM_SWEEP_FILL_EN
  logic [WIDTH-1:0] fill_q;

  // Capture the fill value when a sweep is accepted; held for the whole sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i)      fill_q <= '0;
    else if (start) fill_q <= fill_i;
  end

  assign fill_val = fill_q;
`else
  assign fill_val = '0;
`endif

  // State register: FSM state, sweep pointer and the one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= last_word;
      drop_q  <= (state_q == SWEEP) && load_i;
    end
  end

  // Next-state logic: the pointer stops at DEPTH-1, never walking past the array.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (last_word) begin
          ptr_d   = '0;
          state_d = clear_i ? SWEEP : IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Output logic: status flags straight from the state register.
  always_comb begin
    busy_o = (state_q == SWEEP);
    done_o = done_q;
    drop_o = drop_q;
  end

  // Memory array: reset clears everything, the sweep owns the write port while busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == SWEEP) begin
      mem[ptr_q] <= fill_val;
    end else if (load_i && addr_ok) begin
      mem[address_i] <= in_i;
    end
  end

  // Combinational read; out-of-range addresses read as zero.
  always_comb begin
    out_o = '0;
    if (addr_ok) out_o = mem[address_i];
  end

endmodule

// File: tb/tb_ram_sweep.sv
// tb_ram_sweep: two ram_sweep instances (DEPTH 64 and DEPTH 40, both with a
// 6-bit address) share one stimulus stream. A behavioural model tracks each
// RAM as an array plus a count of sweep cycles remaining; expected outputs are
// queued by the driver and checked by an independent monitor.
module tb_ram_sweep;

  localparam int W  = 16;
  localparam int AW = 6;

  typedef struct packed {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         drop;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  din = '0;
  logic [AW-1:0] addr = '0;

  logic [W-1:0] out_a, out_b;
  logic         busy_a, busy_b, done_a, done_b, drop_a, drop_b;

  always #5 clk = ~clk;

  ram_sweep #(.WIDTH(W), .DEPTH(64)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_i(din), .load_i(load), .address_i(addr),
    .clear_i(clear), .out_o(out_a), .busy_o(busy_a), .done_o(done_a), .drop_o(drop_a)
  );

  ram_sweep #(.WIDTH(W), .DEPTH(40)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_i(din), .load_i(load), .address_i(addr),
    .clear_i(clear), .out_o(out_b), .busy_o(busy_b), .done_o(done_b), .drop_o(drop_b)
  );

  // Reference model state, index 0 = DEPTH 64, index 1 = DEPTH 40.
  logic [W-1:0] mm [2][64];
  int           dep [2];
  int           left [2];
  bit           mdone [2];
  bit           mdrop [2];

  exp_t qa[$];
  exp_t qb[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t model_peek(int d, logic [AW-1:0] a);
    exp_t e;
    e.out  = (int'(a) < dep[d]) ? mm[d][a] : '0;
    e.busy = (left[d] > 0);
    e.done = mdone[d];
    e.drop = mdrop[d];
    return e;
  endfunction

  task automatic model_step(int d, bit r, bit l, bit c, logic [AW-1:0] a, logic [W-1:0] dat);
    bit nd, ndr;
    if (r) begin
      for (int i = 0; i < 64; i++) mm[d][i] = '0;
      left[d]  = 0;
      mdone[d] = 0;
      mdrop[d] = 0;
    end else begin
      nd  = 0;
      ndr = 0;
      if (left[d] > 0) begin
        mm[d][dep[d] - left[d]] = '0;
        ndr = l;
        left[d]--;
        if (left[d] == 0) begin
          nd = 1;
          if (c) left[d] = dep[d];
        end
      end else begin
        if (l && int'(a) < dep[d]) mm[d][a] = dat;
        if (c) left[d] = dep[d];
      end
      mdone[d] = nd;
      mdrop[d] = ndr;
    end
  endtask

  // One stimulus cycle: drive at the falling edge, queue the expected view, advance the model.
  task automatic cycle(bit r, bit l, bit c, logic [AW-1:0] a, logic [W-1:0] dat);
    @(negedge clk);
    rst   = r;
    load  = l;
    clear = c;
    addr  = a;
    din   = dat;
    qa.push_back(model_peek(0, a));
    qb.push_back(model_peek(1, a));
    model_step(0, r, l, c, a, dat);
    model_step(1, r, l, c, a, dat);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, AW'($urandom_range(0, 63)), W'($urandom));
  endtask

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h addr=%0d t=%0t", name, act, req, addr, $time);
    end
  endtask

  // Monitor: compare each presented output set against the queued expectation.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      #2;
      while (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("d64_out",  out_a, ea.out);
        chk("d64_busy", W'(busy_a), W'(ea.busy));
        chk("d64_done", W'(done_a), W'(ea.done));
        chk("d64_drop", W'(drop_a), W'(ea.drop));
        chk("d40_out",  out_b, eb.out);
        chk("d40_busy", W'(busy_b), W'(eb.busy));
        chk("d40_done", W'(done_b), W'(eb.done));
        chk("d40_drop", W'(drop_b), W'(eb.drop));
      end
    end
  end

  initial begin
    dep[0] = 64;
    dep[1] = 40;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) mm[d][i] = '0;
      left[d]  = 0;
      mdone[d] = 0;
      mdrop[d] = 0;
    end

    // Reset, then a single write and neighbour read.
    cycle(1, 0, 0, 6'd0, '0);
    cycle(1, 0, 0, 6'd0, '0);
    cycle(0, 0, 0, 6'd5, '0);
    cycle(0, 1, 0, 6'd5, 16'h00AA);
    cycle(0, 0, 0, 6'd5, '0);
    cycle(0, 0, 0, 6'd6, '0);

    // Fill every word, read a few back, then a one-cycle clear with a write on sweep cycle 10.
    for (int i = 0; i < 64; i++) cycle(0, 1, 0, AW'(i), W'($urandom));
    idle(8);
    cycle(0, 0, 1, 6'd3, '0);
    idle(9);
    cycle(0, 1, 0, 6'd3, 16'h1234);
    idle(60);
    for (int i = 0; i < 64; i++) cycle(0, 0, 0, AW'(i), '0);

    // Reset in the middle of a sweep, then a fresh sweep.
    for (int i = 0; i < 64; i++) cycle(0, 1, 0, AW'(i), W'($urandom));
    cycle(0, 0, 1, 6'd0, '0);
    idle(19);
    cycle(1, 0, 0, 6'd0, '0);
    for (int i = 0; i < 64; i++) cycle(0, 0, 0, AW'(i), '0);
    cycle(0, 0, 1, 6'd0, '0);
    idle(70);

    // Write beyond DEPTH 40 (in range for DEPTH 64).
    cycle(0, 1, 0, 6'd45, 16'hFFFF);
    cycle(0, 0, 0, 6'd45, '0);
    cycle(0, 0, 1, 6'd45, '0);
    idle(70);

    // clear held high: sweeps chain without a gap.
    for (int i = 0; i < 200; i++) cycle(0, ($urandom_range(0, 3) == 0), 1, AW'($urandom_range(0, 63)), W'($urandom));
    idle(70);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0),
            AW'($urandom_range(0, 63)), W'($urandom));
    idle(70);

    @(negedge clk);
    #4;
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    #4;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", qa.size() + qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
